// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   dmem_state_t : responder FSM states
//   dmem_req_t   : latched request (store flag, byte address, store data, byte enables)
//   addr_err     : misaligned / out-of-range check on a byte address
package dmem_pkg;

    localparam int WORD_BYTES = 4;
    // Latched addresses are zero-extended to this width so the range check
    // works for any request address width up to 64 bits.
    localparam int ADDR_MAX_W = 64;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_MAX_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            be;
    } dmem_req_t;

    function automatic logic addr_err(input logic [ADDR_MAX_W-1:0] addr, input int depth);
        return (addr[1:0] != 2'b00) ||
               ((addr >> $clog2(WORD_BYTES)) >= ADDR_MAX_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage.
//   clk, rst : clock, asynchronous active-high clear of every word
//   we, be   : word write strobe and per-byte lane enables
//   re       : registered read strobe; rdata holds until the next read
//   idx      : word index shared by read and write
//   wdata    : store data
//   rdata    : registered read data
//   word1    : combinational view of word 1
module dmem_array #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    input  logic [3:0]               be,
    output logic [31:0]              rdata,
    output logic [31:0]              word1
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

    assign word1 = mem[1];

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder with configurable wait states.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake; req_we/addr/wdata/be latched on accept
//   rsp_valid/rsp_ready   : response handshake; rsp_rdata/rsp_err held until taken
//   mem1                  : live contents of storage word 1
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// WAIT  | request latched, counting down wait states
// RESP  | access done, response presented until rsp_ready
module riscv_dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_be,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [31:0]   mem1
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    dmem_state_t      state_q, state_d;
    dmem_req_t        req_q, req_in, acc_req;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, access, acc_err;
    logic             rsp_err_q, rsp_we_q;
    logic [31:0]      rd_word;

    assign req_in = '{we: req_we, addr: ADDR_MAX_W'(req_addr), wdata: req_wdata, be: req_be};

    // With zero wait states the access happens on the accept edge itself,
    // so it must use the live request rather than the latched copy.
    assign acc_req = (state_q == IDLE) ? req_in : req_q;
    assign acc_err = addr_err(acc_req.addr, DEPTH);

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        access    = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            rsp_err_q <= 1'b0;
            rsp_we_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q <= req_in;
                cnt_q <= LAT_M1;
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (access) begin
                rsp_err_q <= acc_err;
                rsp_we_q  <= acc_req.we;
            end
        end
    end

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (access & acc_req.we & ~acc_err),
        .re   (access & ~acc_req.we & ~acc_err),
        .idx  (acc_req.addr[IW+1:2]),
        .wdata(acc_req.wdata),
        .be   (acc_req.be),
        .rdata(rd_word),
        .word1(mem1)
    );

    // The read register keeps its last load value; stores and errors
    // report zero data without disturbing it.
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid & rsp_err_q;
    assign rsp_rdata = (rsp_valid && !rsp_err_q && !rsp_we_q) ? rd_word : '0;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
module tb_riscv_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;

    logic        ready_a, ready_b, rspv_a, rspv_b, err_a, err_b;
    logic [31:0] rdata_a, rdata_b, mem1_a, mem1_b;
    logic        ready, rspv, err;
    logic [31:0] rdata, mem1;

    int tests = 0;
    int fails = 0;

    // Reference storage for both instances: [0] DEPTH=256 LATENCY=2, [1] DEPTH=16 LATENCY=0
    logic [31:0] mm [2][256];
    int lat_of [2] = '{2, 0};
    int dep_of [2] = '{256, 16};

    always #5 clk = ~clk;

    riscv_dmem_responder #(.DEPTH(256), .LATENCY(2), .AW(32)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rspv_a), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(rdata_a), .rsp_err(err_a), .mem1(mem1_a)
    );

    riscv_dmem_responder #(.DEPTH(16), .LATENCY(0), .AW(32)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rspv_b), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(rdata_b), .rsp_err(err_b), .mem1(mem1_b)
    );

    assign ready = sel ? ready_b : ready_a;
    assign rspv  = sel ? rspv_b  : rspv_a;
    assign err   = sel ? err_b   : err_a;
    assign rdata = sel ? rdata_b : rdata_a;
    assign mem1  = sel ? mem1_b  : mem1_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++)
                mm[s][i] = '0;
    endtask

    // One full request/response with the spec's rules applied to the model.
    // While the response is held, a conflicting store is pushed at the
    // responder; it must not be taken.
    task automatic txn(input bit s, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold);
        int n;
        bit e;
        int idx;
        logic [31:0] exp_rd;
        @(negedge clk);
        sel = s; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        #1;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!rspv && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'(lat_of[s] + 1));

        e = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(dep_of[s]));
        idx = e ? 0 : int'(addr >> 2);
        exp_rd = (!e && !we) ? mm[s][idx] : 32'h0;
        if (!e && we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mm[s][idx][8*b +: 8] = wdata[8*b +: 8];

        check("rsp_err", 32'(err), 32'(e));
        check("rsp_rdata", rdata, exp_rd);
        check("mem1", mem1, mm[s][1]);
        check("req_ready_resp", 32'(ready), 32'd0);

        if (hold > 0) begin
            req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
            req_valid = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rspv), 32'd1);
            check("hold_rdata", rdata, exp_rd);
            check("hold_ready", 32'(ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("post_rsp_valid", 32'(rspv), 32'd0);
        check("post_ready", 32'(ready), 32'd1);
        check("post_mem1", mem1, mm[s][1]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, idx, d;
        logic [31:0] a;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            check("rst_ready", 32'(ready), 32'd1);
            check("rst_rspv", 32'(rspv), 32'd0);
            check("rst_rdata", rdata, 32'h0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_mem1", mem1, 32'h0);
        end
        @(negedge clk); rst = 1'b0;

        // Directed: store, load, partial store, errors, held response, be=0
        txn(0, 1, 32'h4, 32'hDEAD_BEEF, 4'hF, 0);
        txn(0, 0, 32'h4, 32'h0, 4'hF, 0);
        txn(0, 1, 32'h4, 32'h0000_AA00, 4'b0010, 0);
        txn(0, 0, 32'h4, 32'h0, 4'h0, 0);
        check("partial_model", mm[0][1], 32'hDEAD_AAEF);
        txn(0, 0, 32'h6, 32'h0, 4'hF, 0);
        txn(0, 0, 32'd1024, 32'h0, 4'hF, 0);
        txn(0, 1, 32'h7, 32'h1111_1111, 4'hF, 0);
        txn(0, 0, 32'h4, 32'h0, 4'hF, 5);
        txn(0, 1, 32'h4, 32'hFFFF_FFFF, 4'h0, 0);
        txn(0, 0, 32'h4, 32'h0, 4'hF, 0);

        // Reset during WAIT of a store
        @(negedge clk);
        sel = 1'b0; req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'h1234_5678; req_be = 4'hF;
        req_valid = 1'b1;
        #1;
        check("mid_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_wait_ready", 32'(ready), 32'd0);
        check("mid_wait_rspv", 32'(rspv), 32'd0);
        rst = 1'b1;
        clear_model();
        #1;
        check("mid_rst_rspv", 32'(rspv), 32'd0);
        check("mid_rst_mem1", mem1, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rel_ready", 32'(ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("mid_no_rsp", 32'(rspv), 32'd0);
            check("mid_mem1", mem1, 32'h0);
        end

        // Zero-wait instance
        txn(1, 1, 32'h8, 32'hCAFE_F00D, 4'hF, 0);
        txn(1, 0, 32'h8, 32'h0, 4'hF, 0);
        txn(1, 1, 32'h4, 32'hA5A5_5A5A, 4'b1001, 0);
        txn(1, 0, 32'd64, 32'h0, 4'hF, 2);
        txn(1, 0, 32'h4, 32'h0, 4'hF, 0);

        // Randomized traffic on both instances
        for (int t = 0; t < 60; t++) begin
            sel = 1'($urandom_range(0, 1));
            d = dep_of[sel];
            idx = $urandom_range(0, 7);
            mode = $urandom_range(0, 9);
            if (mode == 0)      a = 32'(idx * 4 + $urandom_range(1, 3));
            else if (mode == 1) a = 32'(d * 4 + 4 * $urandom_range(0, 3));
            else                a = 32'(idx * 4);
            txn(sel, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
